// File: rtl/bf_pkg.sv
// Shared types, constants and helpers for the Bloom filter blocks.
package bf_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_HASH,
        ST_PROBE,
        ST_RESP
    } bf_state_e;

    localparam logic BF_OP_QUERY  = 1'b0;
    localparam logic BF_OP_INSERT = 1'b1;

    localparam logic [31:0] BF_SEED_A = 32'hdeadbef8;
    localparam logic [31:0] BF_SEED_B = 32'hdeadbef1;

    // Rotate left by n; the upper half of the shifted doubled word is the rotation.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

endpackage

// File: rtl/bf_mix_hash.sv
// Six-step iterative mix of a 96-bit key into two 32-bit hashes (h2 forced odd).
module bf_mix_hash
    import bf_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [95:0] key96_i,
    output logic        done_o,
    output logic [31:0] h1_o,
    output logic [31:0] h2_o
);

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [2:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // After step 6, c holds h1 and b holds b2, from which h2 is derived.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            a_d    = BF_SEED_A + key96_i[95:64];
            b_d    = BF_SEED_B + key96_i[63:32];
            c_d    = BF_SEED_A + key96_i[31:0];
            step_d = 3'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            step_d = step_q + 3'd1;
            case (step_q)
                3'd1: c_d = (c_q ^ b_q) - rol32(b_q, 5'd14);
                3'd2: a_d = (a_q ^ c_q) - rol32(c_q, 5'd11);
                3'd3: b_d = (b_q ^ a_q) - rol32(a_q, 5'd25);
                3'd4: a_d = (a_q ^ c_q) - rol32(c_q, 5'd4);
                3'd5: b_d = (b_q ^ a_q) - rol32(a_q, 5'd14);
                3'd6: begin
                    c_d    = (c_q ^ b_q) - rol32(b_q, 5'd24);
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: busy_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign h1_o   = c_q;
    assign h2_o   = b_q | 32'd1;

endmodule

// File: rtl/bloom_filter_kh.sv
// K-probe Bloom filter: one hash per key, double-hashed probes, clear sequencer.
module bloom_filter_kh
    import bf_pkg::*;
#(
    parameter int KEY_W  = 72,
    parameter int M_BITS = 1024,
    parameter int K_HASH = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_op_i,
    input  logic [KEY_W-1:0]            req_key_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic                        rsp_hit_o,
    input  logic                        clr_start_i,
    output logic                        clr_busy_o,
    output logic [$clog2(M_BITS+1)-1:0] fill_count_o
);

    localparam int IDX_W  = $clog2(M_BITS);
    localparam int WORDS  = M_BITS / 32;
    localparam int PTR_W  = $clog2(WORDS);
    localparam int FILL_W = $clog2(M_BITS + 1);
    localparam logic [2:0]       PROBE_LAST = 3'(K_HASH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(WORDS - 1);

    bf_state_e         state_q;
    logic              op_q;
    logic [PTR_W-1:0]  clr_ptr_q;
    logic [2:0]        probe_q;
    logic [31:0]       acc_q;
    logic              hit_q;
    logic [FILL_W-1:0] fill_q;
    logic              rsp_valid_q;
    logic              clr_busy_q;
    logic [31:0]       mem_q [WORDS];

    logic              accept;
    logic              hash_done;
    logic [31:0]       h1;
    logic [31:0]       h2;
    logic [IDX_W-1:0]  idx;
    logic [PTR_W-1:0]  word_sel;
    logic [4:0]        bit_sel;
    logic              probe_bit;

    assign req_ready_o = (state_q == ST_IDLE) && !clr_start_i;
    assign accept      = req_valid_i && req_ready_o;

    bf_mix_hash u_hash (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (accept),
        .key96_i (96'(req_key_i)),
        .done_o  (hash_done),
        .h1_o    (h1),
        .h2_o    (h2)
    );

    // acc_q walks h1, h1+h2, h1+2*h2, ...; its low bits are the probe index.
    assign idx       = acc_q[IDX_W-1:0];
    assign word_sel  = idx[IDX_W-1:5];
    assign bit_sel   = idx[4:0];
    assign probe_bit = mem_q[word_sel][bit_sel];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_CLEAR;
            op_q        <= BF_OP_QUERY;
            clr_ptr_q   <= '0;
            probe_q     <= '0;
            acc_q       <= '0;
            hit_q       <= 1'b0;
            fill_q      <= '0;
            rsp_valid_q <= 1'b0;
            clr_busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + PTR_W'(1);
                    fill_q    <= '0;
                    if (clr_ptr_q == PTR_LAST) begin
                        state_q    <= ST_IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr_start_i) begin
                        state_q    <= ST_CLEAR;
                        clr_busy_q <= 1'b1;
                        clr_ptr_q  <= '0;
                        fill_q     <= '0;
                    end else if (req_valid_i) begin
                        op_q    <= req_op_i;
                        hit_q   <= 1'b1;
                        state_q <= ST_HASH;
                    end
                end
                ST_HASH: begin
                    if (hash_done) begin
                        acc_q   <= h1;
                        probe_q <= '0;
                        state_q <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    hit_q   <= hit_q & probe_bit;
                    acc_q   <= acc_q + h2;
                    probe_q <= probe_q + 3'd1;
                    if ((op_q == BF_OP_INSERT) && !probe_bit) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                    if (probe_q == PROBE_LAST) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    clr_ptr_q  <= '0;
                    clr_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // The array is never reset directly; CLEAR always follows reset and wipes it.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if ((state_q == ST_PROBE) && (op_q == BF_OP_INSERT)) begin
            mem_q[word_sel][bit_sel] <= 1'b1;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_hit_o    = hit_q;
    assign clr_busy_o   = clr_busy_q;
    assign fill_count_o = fill_q;

endmodule

// File: tb/tb_bloom_filter_kh.sv
// Scoreboard bench for bloom_filter_kh: directed requests, queued expectations, negedge monitor.
module tb_bloom_filter_kh;

    localparam int KW = 72;
    localparam int M  = 1024;
    localparam int K  = 3;
    localparam int FW = $clog2(M + 1);

    localparam logic [KW-1:0] KEY1 = 72'h0A0000011122330006;
    localparam logic [KW-1:0] KEY2 = 72'hC0A8000150001F9011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [KW-1:0] req_key = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_hit;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic [FW-1:0] fill_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    int   acc_cnt = 0;
    logic prev_valid = 1'b0;
    logic sb [$];

    logic model_arr [M];
    int   model_fill = 0;

    bloom_filter_kh #(.KEY_W(KW), .M_BITS(M), .K_HASH(K)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_key_i    (req_key),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_hit_o    (rsp_hit),
        .clr_start_i  (clr_start),
        .clr_busy_o   (clr_busy),
        .fill_count_o (fill_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "[TB] watchdog");
    end

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] refRol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic refHash(input logic [KW-1:0] key, output logic [31:0] h1,
                           output logic [31:0] h2);
        logic [95:0] k;
        logic [31:0] a, b, c;
        k = 96'(key);
        a = 32'hdeadbef8 + k[95:64];
        b = 32'hdeadbef1 + k[63:32];
        c = 32'hdeadbef8 + k[31:0];
        c = (c ^ b) - refRol(b, 14);
        a = (a ^ c) - refRol(c, 11);
        b = (b ^ a) - refRol(a, 25);
        a = (a ^ c) - refRol(c, 4);
        b = (b ^ a) - refRol(a, 14);
        h1 = (c ^ b) - refRol(b, 24);
        h2 = b | 32'd1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < M; i++) model_arr[i] = 1'b0;
        model_fill = 0;
    endtask

    task automatic modelApply(input logic op, input logic [KW-1:0] key, output logic hit);
        logic [31:0] h1, h2, s;
        int idx;
        refHash(key, h1, h2);
        hit = 1'b1;
        for (int i = 0; i < K; i++) begin
            s   = h1 + 32'(i) * h2;
            idx = int'(s % 32'(M));
            hit = hit & model_arr[idx];
            if (op && !model_arr[idx]) begin
                model_arr[idx] = 1'b1;
                model_fill++;
            end
        end
    endtask

    // Issue one request; the expected hit is queued before the DUT can answer.
    task automatic applyStimulus(input logic op, input logic [KW-1:0] key);
        logic exp;
        int n;
        modelApply(op, key, exp);
        sb.push_back(exp);
        req_op    = op;
        req_key   = key;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_in_time", 32'(n < 200), 1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_idle_in_time"}, 32'(n < 300), 1);
    endtask

    task automatic waitClear(input string name);
        int n, busy;
        n = 0;
        busy = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!clr_busy) break;
            busy++;
            checkOutput("req_ready_in_clear", 32'(req_ready), 0);
            checkOutput("fill_in_clear", 32'(fill_count), 0);
        end
        checkOutput({name, "_clear_cycles"}, 32'(busy), M / 32);
        checkOutput({name, "_ready_after_clear"}, 32'(req_ready), 1);
    endtask

    // Monitor: records accepts, checks latency on each rise and hit on each handshake.
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            acc_edge = cyc + 1;
            acc_cnt++;
        end
        if (rsp_valid && !prev_valid) begin
            checkOutput("rsp_expected", 32'(sb.size() != 0), 1);
            checkOutput("latency", 32'(cyc - acc_edge), K + 7);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_queue_nonempty", 0, 1);
            end else begin
                checkOutput("rsp_hit", 32'(rsp_hit), 32'(sb.pop_front()));
            end
        end
        prev_valid = rsp_valid;
    end

    initial begin
        logic exp_hold;
        int acc_before;
        int fill_before;
        int n;

        modelClear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_clr_busy", 32'(clr_busy), 1);
        checkOutput("reset_req_ready", 32'(req_ready), 0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_rsp_hit", 32'(rsp_hit), 0);
        checkOutput("reset_fill", 32'(fill_count), 0);
        @(posedge clk);
        #2;
        reset     = 1'b0;
        req_op    = 1'b0;
        req_key   = KEY1;
        req_valid = 1'b1;
        waitClear("boot");
        checkOutput("boot_fill", 32'(fill_count), 0);

        // Query on empty array, then insert twice and query.
        applyStimulus(1'b0, KEY1);
        waitIdle("q_empty");
        checkOutput("fill_after_query", 32'(fill_count), 0);
        @(posedge clk);
        #2;
        applyStimulus(1'b1, KEY1);
        waitIdle("ins1");
        checkOutput("fill_after_insert1", 32'(fill_count), 32'(model_fill));
        checkOutput("fill_ins1_in_range", 32'(fill_count >= 1 && fill_count <= 3), 1);
        fill_before = int'(fill_count);
        @(posedge clk);
        #2;
        applyStimulus(1'b1, KEY1);
        waitIdle("ins2");
        checkOutput("fill_after_insert2", 32'(fill_count), 32'(fill_before));
        @(posedge clk);
        #2;
        applyStimulus(1'b0, KEY1);
        waitIdle("q_hit");
        @(posedge clk);
        #2;
        applyStimulus(1'b1, KEY2);
        waitIdle("ins_key2");
        checkOutput("fill_after_key2", 32'(fill_count), 32'(model_fill));
        @(posedge clk);
        #2;
        applyStimulus(1'b0, KEY2);
        waitIdle("q_key2");

        // Back-pressure: response must hold while rsp_ready is low.
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, KEY1);
        exp_hold = sb[0];
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_rsp_seen", 32'(rsp_valid), 1);
        @(posedge clk);
        #2;
        req_op     = 1'b0;
        req_key    = KEY2;
        req_valid  = 1'b1;
        acc_before = acc_cnt;
        repeat (12) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 1);
            checkOutput("hold_rsp_hit", 32'(rsp_hit), 32'(exp_hold));
            checkOutput("hold_req_ready", 32'(req_ready), 0);
        end
        checkOutput("hold_no_accept", 32'(acc_cnt), 32'(acc_before));
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        waitIdle("hold");

        // clr_start and req_valid together: the clear wins.
        @(posedge clk);
        #2;
        clr_start = 1'b1;
        req_op    = 1'b0;
        req_key   = KEY1;
        req_valid = 1'b1;
        @(negedge clk);
        checkOutput("clr_start_blocks_ready", 32'(req_ready), 0);
        @(posedge clk);
        #2;
        clr_start = 1'b0;
        modelClear();
        waitClear("clr");
        applyStimulus(1'b0, KEY1);
        waitIdle("q_after_clr");
        checkOutput("fill_after_clr", 32'(fill_count), 0);

        // Reset during PROBE of an insert: response dropped, array wiped.
        @(posedge clk);
        #2;
        applyStimulus(1'b1, KEY1);
        waitIdle("ins_before_abort");
        @(posedge clk);
        #2;
        req_op    = 1'b1;
        req_key   = KEY2;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        modelClear();
        waitClear("abort");
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("abort_fill", 32'(fill_count), 0);
        applyStimulus(1'b0, KEY2);
        waitIdle("q_key2_after_abort");
        @(posedge clk);
        #2;
        applyStimulus(1'b0, KEY1);
        waitIdle("q_key1_after_abort");
        checkOutput("final_fill", 32'(fill_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
